// File: rtl/rr_arb_pkg.sv
// Shared constants, FSM state type and index helper for the 32-way round-robin arbiter.
package rr_arb_pkg;
    localparam int N      = 32;
    localparam int IDXW   = 5;
    localparam int HOLD_W = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    function automatic logic [IDXW-1:0] onehot2idx(input logic [N-1:0] oh);
        logic [IDXW-1:0] idx;
        idx = '0;
        for (int i = 0; i < N; i++) begin
            if (oh[i]) idx |= i[IDXW-1:0];
        end
        return idx;
    endfunction
endpackage

// File: rtl/rr_arbiter32_if.sv
// Client-side request/grant bundle between the 32 requesters and the arbiter.
interface rr_arbiter32_if;
    import rr_arb_pkg::*;

    // Handshake: req[i] is a level that stays high while requester i wants the
    // resource; gnt is one-hot and held until the owner raises done for a cycle
    // or drops its req bit; gnt_valid mirrors |gnt; timeout pulses when the
    // arbiter revokes a grant on its own.
    logic [N-1:0]    req;
    logic            done;
    logic [N-1:0]    gnt;
    logic            gnt_valid;
    logic [IDXW-1:0] gnt_idx;
    logic            timeout;

    modport master (
        output req, done,
        input  gnt, gnt_valid, gnt_idx, timeout
    );

    modport slave (
        input  req, done,
        output gnt, gnt_valid, gnt_idx, timeout
    );
endinterface

// File: rtl/rr_arbiter32_lsb_isolate32.sv
// Keeps only the lowest set bit of a 32-bit vector using a prefix-OR tree.
module lsb_isolate32 (
    input  logic [31:0] x,
    output logic [31:0] y
);
    // lvl[l+1][i] covers x[i] down to the start of its 2^(l+1)-aligned block.
    logic [5:0][31:0] lvl;

    assign lvl[0] = x;

    for (genvar l = 0; l < 5; l++) begin : g_lvl
        for (genvar i = 0; i < 32; i++) begin : g_bit
            if (((i >> l) & 1) == 1) begin : g_merge
                assign lvl[l+1][i] = lvl[l][i] | lvl[l][((i >> l) << l) - 1];
            end else begin : g_pass
                assign lvl[l+1][i] = lvl[l][i];
            end
        end
    end

    assign y[0] = x[0];
    for (genvar i = 1; i < 32; i++) begin : g_out
        assign y[i] = x[i] & ~lvl[5][i-1];
    end
endmodule

// File: rtl/rr_arbiter32.sv
// Round-robin arbiter over 32 level requesters with registered one-hot grant and optional hold limit.
module rr_arbiter32
    import rr_arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 0
) (
    input  logic            clk,
    input  logic            rst,
    rr_arbiter32_if.slave   bus,
    output state_e          state_o,
    output logic [IDXW-1:0] ptr_o
);
    localparam logic [HOLD_W-1:0] HOLD_LAST =
        (MAX_HOLD == 0) ? '0 : HOLD_W'(MAX_HOLD - 1);

    state_e            state_q, state_d;
    logic [N-1:0]      gnt_q, gnt_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic [IDXW-1:0]   ptr_q, ptr_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              timeout_q, timeout_d;

    logic [N-1:0] masked, iso_masked, iso_req, win_oh;
    logic         rel_owner, rel_hold;

    assign masked = bus.req & ({N{1'b1}} << ptr_q);

    lsb_isolate32 u_iso_masked (.x(masked),  .y(iso_masked));
    lsb_isolate32 u_iso_req    (.x(bus.req), .y(iso_req));

    // Requests at or above the pointer win first; otherwise wrap to the lowest.
    assign win_oh    = (|masked) ? iso_masked : iso_req;
    assign rel_owner = bus.done || !bus.req[idx_q];
    assign rel_hold  = (MAX_HOLD != 0) && (hold_q == HOLD_LAST);

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        idx_d     = idx_q;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        timeout_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (|bus.req) begin
                    gnt_d   = win_oh;
                    idx_d   = onehot2idx(win_oh);
                    hold_d  = '0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (rel_owner || rel_hold) begin
                    gnt_d     = '0;
                    ptr_d     = idx_q + 1'b1;
                    timeout_d = rel_hold && !rel_owner;
                    state_d   = IDLE;
                end else if (hold_q != '1) begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            idx_q     <= '0;
            ptr_q     <= '0;
            hold_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            idx_q     <= idx_d;
            ptr_q     <= ptr_d;
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.gnt_valid = |gnt_q;
    assign bus.gnt_idx   = idx_q;
    assign bus.timeout   = timeout_q;
    assign state_o       = state_q;
    assign ptr_o         = ptr_q;
endmodule

// File: tb/tb_rr_arbiter32.sv
// Bench for rr_arbiter32: one instance without hold limit, one with a limit of 4 cycles.
module tb_rr_arbiter32;
    import rr_arb_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic [31:0] req_s;
    logic done_s;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rr_arbiter32_if bus0 ();
    rr_arbiter32_if bus4 ();
    state_e st0, st4;
    logic [4:0] ptr0, ptr4;

    assign bus0.req  = req_s;
    assign bus0.done = done_s;
    assign bus4.req  = req_s;
    assign bus4.done = done_s;

    rr_arbiter32 #(.MAX_HOLD(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0), .state_o(st0), .ptr_o(ptr0));
    rr_arbiter32 #(.MAX_HOLD(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4), .state_o(st4), .ptr_o(ptr4));

    // Reference model: owner number (-1 = free), cycles held so far, next start point.
    int m_owner[2];
    int m_idx[2];
    int m_ptr[2];
    int m_held[2];
    bit m_to[2];

    function automatic int pick(input logic [31:0] r, input int p);
        for (int j = p; j < 32; j++) if (r[j]) return j;
        for (int j = 0; j < 32; j++) if (r[j]) return j;
        return -1;
    endfunction

    task automatic model_step(input int k);
        int lim;
        bit by_owner, by_limit;
        lim = (k == 1) ? 4 : 0;
        if (rst) begin
            m_owner[k] = -1; m_idx[k] = 0; m_ptr[k] = 0; m_held[k] = 0; m_to[k] = 0;
        end else if (m_owner[k] < 0) begin
            m_to[k] = 0;
            if (req_s != 0) begin
                m_owner[k] = pick(req_s, m_ptr[k]);
                m_idx[k]   = m_owner[k];
                m_held[k]  = 1;
            end
        end else begin
            by_owner = done_s || !req_s[m_owner[k]];
            by_limit = (lim != 0) && (m_held[k] == lim);
            m_to[k]  = by_limit && !by_owner;
            if (by_owner || by_limit) begin
                m_ptr[k]   = (m_owner[k] + 1) % 32;
                m_owner[k] = -1;
            end else begin
                m_held[k]++;
            end
        end
    endtask

    function automatic logic [38:0] mdl(input int k);
        logic [31:0] g;
        g = (m_owner[k] >= 0) ? (32'h1 << m_owner[k]) : 32'h0;
        return {g, |g, m_idx[k][4:0], m_to[k]};
    endfunction

    function automatic logic [38:0] obs(input int k);
        if (k == 0) return {bus0.gnt, bus0.gnt_valid, bus0.gnt_idx, bus0.timeout};
        return {bus4.gnt, bus4.gnt_valid, bus4.gnt_idx, bus4.timeout};
    endfunction

    task automatic tick();
        model_step(0);
        model_step(1);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; req_s = '0; done_s = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        for (int c = 0; c < 5; c++) begin
            tick();
            checks++;
            if (bus0.gnt !== 32'h0 || bus0.gnt_valid !== 1'b0 || bus0.timeout !== 1'b0 ||
                bus4.gnt !== 32'h0 || bus4.gnt_valid !== 1'b0 || bus4.timeout !== 1'b0) begin
                errors++;
                $display("FAIL reset_idle c%0d got gnt0=%h gnt4=%h v=%b%b to=%b%b exp all zero",
                         c, bus0.gnt, bus4.gnt, bus0.gnt_valid, bus4.gnt_valid, bus0.timeout, bus4.timeout);
            end
        end
        checks++;
        if (st4 !== IDLE || ptr4 !== 5'd0 || bus4.gnt_idx !== 5'd0) begin
            errors++;
            $display("FAIL reset_state got st=%0d ptr=%0d idx=%0d exp 0 0 0", st4, ptr4, bus4.gnt_idx);
        end
    endtask

    task automatic test_wrap();
        int owners[4] = '{0, 2, 31, 0};
        logic [31:0] exp_g;
        do_reset();
        req_s = 32'h8000_0005;
        for (int n = 0; n < 4; n++) begin
            tick();
            exp_g = 32'h1 << owners[n];
            checks++;
            if (bus4.gnt !== exp_g || bus0.gnt !== exp_g || bus4.gnt_idx !== 5'(owners[n])) begin
                errors++;
                $display("FAIL wrap_owner%0d got gnt4=%h gnt0=%h idx=%0d exp %h", n, bus4.gnt, bus0.gnt,
                         bus4.gnt_idx, exp_g);
            end
            done_s = 1'b1;
            tick();
            done_s = 1'b0;
            checks++;
            if (bus4.gnt !== 32'h0 || bus4.gnt_valid !== 1'b0 || bus0.gnt !== 32'h0 || bus4.timeout !== 1'b0) begin
                errors++;
                $display("FAIL wrap_gap%0d got gnt4=%h v=%b gnt0=%h to=%b exp 0", n, bus4.gnt,
                         bus4.gnt_valid, bus0.gnt, bus4.timeout);
            end
        end
        req_s = '0;
        tick();
    endtask

    task automatic test_hold_limit();
        logic [31:0] exp_g[10] = '{32'h1, 32'h1, 32'h1, 32'h1, 32'h0, 32'h2, 32'h2, 32'h2, 32'h2, 32'h0};
        bit exp_to[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
        do_reset();
        req_s = 32'h0000_0003;
        for (int c = 0; c < 10; c++) begin
            tick();
            checks++;
            if (bus4.gnt !== exp_g[c] || bus4.timeout !== exp_to[c]) begin
                errors++;
                $display("FAIL hold_limit c%0d got gnt=%h to=%b exp gnt=%h to=%b", c, bus4.gnt,
                         bus4.timeout, exp_g[c], exp_to[c]);
            end
            checks++;
            if (bus0.gnt !== 32'h1 || bus0.timeout !== 1'b0) begin
                errors++;
                $display("FAIL hold_unlimited c%0d got gnt=%h to=%b exp gnt=1 to=0", c, bus0.gnt, bus0.timeout);
            end
        end
        req_s = '0;
        tick();
    endtask

    task automatic test_abandon();
        do_reset();
        req_s = 32'h0000_0080;
        tick();
        tick();
        checks++;
        if (bus4.gnt !== 32'h80) begin
            errors++;
            $display("FAIL abandon_grant got %h exp 00000080", bus4.gnt);
        end
        req_s = 32'h0;
        tick();
        checks++;
        if (bus4.gnt !== 32'h0 || bus4.timeout !== 1'b0 || ptr4 !== 5'd8 || bus4.gnt_idx !== 5'd7) begin
            errors++;
            $display("FAIL abandon_release got gnt=%h to=%b ptr=%0d idx=%0d exp 0 0 8 7", bus4.gnt,
                     bus4.timeout, ptr4, bus4.gnt_idx);
        end
        req_s = 32'h0000_0180;
        tick();
        checks++;
        if (bus4.gnt !== 32'h100 || bus4.gnt_idx !== 5'd8 || bus0.gnt !== 32'h100) begin
            errors++;
            $display("FAIL abandon_next got gnt4=%h idx=%0d gnt0=%h exp 00000100 8", bus4.gnt,
                     bus4.gnt_idx, bus0.gnt);
        end
        req_s = '0;
        tick();
    endtask

    task automatic test_done_and_limit();
        do_reset();
        req_s = 32'h0000_0001;
        for (int c = 0; c < 4; c++) tick();
        done_s = 1'b1;
        tick();
        done_s = 1'b0;
        checks++;
        if (bus4.gnt !== 32'h0 || bus4.timeout !== 1'b0) begin
            errors++;
            $display("FAIL done_with_limit got gnt=%h to=%b exp 0 0", bus4.gnt, bus4.timeout);
        end
        req_s = '0;
        tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        req_s = 32'h0000_0800;
        tick();
        done_s = 1'b1;
        tick();
        done_s = 1'b0;
        req_s = 32'h0000_1000;
        tick();
        tick();
        checks++;
        if (bus4.gnt !== 32'h1000) begin
            errors++;
            $display("FAIL rst_mid_owner got %h exp 00001000", bus4.gnt);
        end
        rst = 1'b1;
        req_s = 32'h0000_1001;
        tick();
        rst = 1'b0;
        checks++;
        if (bus4.gnt !== 32'h0 || bus4.gnt_valid !== 1'b0 || ptr4 !== 5'd0 || st4 !== IDLE) begin
            errors++;
            $display("FAIL rst_mid_clear got gnt=%h v=%b ptr=%0d exp 0 0 0", bus4.gnt, bus4.gnt_valid, ptr4);
        end
        tick();
        checks++;
        if (bus4.gnt !== 32'h1 || bus0.gnt !== 32'h1) begin
            errors++;
            $display("FAIL rst_mid_next got gnt4=%h gnt0=%h exp 00000001", bus4.gnt, bus0.gnt);
        end
        req_s = '0;
        tick();
    endtask

    task automatic test_random();
        logic [31:0] g;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 2) == 0) begin
                case ($urandom_range(0, 3))
                    0:       req_s = '0;
                    1:       req_s = 32'h1 << $urandom_range(0, 31);
                    2:       req_s = $urandom;
                    default: req_s = $urandom & $urandom & $urandom;
                endcase
            end
            done_s = ($urandom_range(0, 5) == 0);
            rst    = ($urandom_range(0, 99) == 0);
            tick();
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (obs(k) !== mdl(k)) begin
                    errors++;
                    $display("FAIL random_model dut%0d c%0d got %h exp %h", k * 4, c, obs(k), mdl(k));
                end
                g = (k == 0) ? bus0.gnt : bus4.gnt;
                checks++;
                if ($countones(g) > 1 || ((k == 0) ? bus0.gnt_valid : bus4.gnt_valid) !== (|g)) begin
                    errors++;
                    $display("FAIL random_onehot dut%0d c%0d got gnt=%h exp at most one bit, valid=|gnt",
                             k * 4, c, g);
                end
            end
        end
        rst = 1'b0;
        done_s = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        req_s = '0;
        done_s = 1'b0;
        for (int k = 0; k < 2; k++) begin
            m_owner[k] = -1; m_idx[k] = 0; m_ptr[k] = 0; m_held[k] = 0; m_to[k] = 0;
        end
        test_reset();
        test_wrap();
        test_hold_limit();
        test_abandon();
        test_done_and_limit();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
